// File: rtl/aes_pkg.sv
// Shared definitions for the time-multiplexed AES S-box scheduler:
// FSM state encoding, byte width, default job lengths and counter width.
package aes_pkg;

  localparam int BYTE_W   = 8;
  localparam int ST_BYTES = 16;
  localparam int KW_BYTES = 4;
  localparam int CNT_W    = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN_ST  = 3'd1,
    RUN_KW  = 3'd2,
    DONE_ST = 3'd3,
    DONE_KW = 3'd4
  } sched_state_e;

endpackage

// File: rtl/tt_um_sub_bytes.sv
// Single-byte AES S-box, purely combinational.
// Computes the GF(2^8) multiplicative inverse as a^254 (0 maps to 0),
// then applies the AES affine transform with constant 0x63.
module tt_um_sub_bytes (
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam logic [7:0] AFFINE_C = 8'h63;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;

  // Inverse via square-and-multiply, then the affine map
  always_comb begin
    logic [7:0] pw;
    inv = 8'h01;
    pw  = data_in;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    data_out = 8'h00;
    for (int i = 0; i < 8; i++) begin
      data_out[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^
                    inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ AFFINE_C[i];
    end
  end

endmodule

// File: rtl/aes_sbox_sched.sv
// Shares one tt_um_sub_bytes lookup between the round datapath (16-byte
// SubBytes) and the key schedule (4-byte SubWord), one byte per cycle,
// one job in flight. Define AES_SBOX_SCHED_RR_EN for round-robin
// arbitration on simultaneous requests; otherwise KEY_PRIORITY decides.
module aes_sbox_sched
  import aes_pkg::*;
#(
  parameter bit KEY_PRIORITY = 1'b1,
  parameter int ST_BYTES     = aes_pkg::ST_BYTES,
  parameter int KW_BYTES     = aes_pkg::KW_BYTES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         st_in_valid,
  output logic                         st_in_ready,
  input  logic [ST_BYTES*BYTE_W-1:0]   st_in_data,
  output logic                         st_out_valid,
  input  logic                         st_out_ready,
  output logic [ST_BYTES*BYTE_W-1:0]   st_out_data,
  input  logic                         kw_in_valid,
  output logic                         kw_in_ready,
  input  logic [KW_BYTES*BYTE_W-1:0]   kw_in_data,
  output logic                         kw_out_valid,
  input  logic                         kw_out_ready,
  output logic [KW_BYTES*BYTE_W-1:0]   kw_out_data,
  output logic                         busy
);

  localparam int ST_W = ST_BYTES * BYTE_W;
  localparam int KW_W = KW_BYTES * BYTE_W;
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(ST_BYTES - 1);
  localparam logic [CNT_W-1:0] KW_LAST = CNT_W'(KW_BYTES - 1);

  sched_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ST_W-1:0]   work_q, work_d;
  logic              st_out_valid_q, st_out_valid_d;
  logic              kw_out_valid_q, kw_out_valid_d;
  logic              busy_q, busy_d;
  logic              key_first;
  logic              grant_kw, grant_st;
  logic [BYTE_W-1:0] sbox_in, sbox_out;

`ifdef AES_SBOX_SCHED_RR_EN
  // last_kw_q = 1 when the key word was the most recent grant
  logic last_kw_q, last_kw_d;
  assign key_first = ~last_kw_q;
`else
  assign key_first = KEY_PRIORITY;
`endif

  assign grant_kw    = (state_q == IDLE) && kw_in_valid && (!st_in_valid || key_first);
  assign grant_st    = (state_q == IDLE) && st_in_valid && !grant_kw;
  assign kw_in_ready = grant_kw;
  assign st_in_ready = grant_st;

  assign st_out_valid = st_out_valid_q;
  assign kw_out_valid = kw_out_valid_q;
  assign busy         = busy_q;
  assign st_out_data  = (state_q == DONE_ST) ? work_q : '0;
  assign kw_out_data  = (state_q == DONE_KW) ? work_q[KW_W-1:0] : '0;

  // Feed the current byte to the shared S-box only while a job is running
  always_comb begin
    sbox_in = '0;
    if (state_q == RUN_ST || state_q == RUN_KW) begin
      sbox_in = work_q[int'(cnt_q)*BYTE_W +: BYTE_W];
    end
  end

  tt_um_sub_bytes u_sbox (
    .data_in  (sbox_in),
    .data_out (sbox_out)
  );

  // Next-state logic: accept, substitute byte by byte, hold result until taken
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    work_d         = work_q;
    st_out_valid_d = st_out_valid_q;
    kw_out_valid_d = kw_out_valid_q;
    busy_d         = busy_q;
`ifdef AES_SBOX_SCHED_RR_EN
    last_kw_d      = last_kw_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_kw) begin
          work_d           = '0;
          work_d[KW_W-1:0] = kw_in_data;
          cnt_d            = '0;
          state_d          = RUN_KW;
          busy_d           = 1'b1;
`ifdef AES_SBOX_SCHED_RR_EN
          last_kw_d        = 1'b1;
`endif
        end else if (grant_st) begin
          work_d  = st_in_data;
          cnt_d   = '0;
          state_d = RUN_ST;
          busy_d  = 1'b1;
`ifdef AES_SBOX_SCHED_RR_EN
          last_kw_d = 1'b0;
`endif
        end
      end
      RUN_ST: begin
        work_d[int'(cnt_q)*BYTE_W +: BYTE_W] = sbox_out;
        if (cnt_q == ST_LAST) begin
          state_d        = DONE_ST;
          st_out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN_KW: begin
        work_d[int'(cnt_q)*BYTE_W +: BYTE_W] = sbox_out;
        if (cnt_q == KW_LAST) begin
          state_d        = DONE_KW;
          kw_out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE_ST: begin
        if (st_out_ready) begin
          state_d        = IDLE;
          st_out_valid_d = 1'b0;
          busy_d         = 1'b0;
          cnt_d          = '0;
        end
      end
      DONE_KW: begin
        if (kw_out_ready) begin
          state_d        = IDLE;
          kw_out_valid_d = 1'b0;
          busy_d         = 1'b0;
          cnt_d          = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any job in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      work_q         <= '0;
      st_out_valid_q <= 1'b0;
      kw_out_valid_q <= 1'b0;
      busy_q         <= 1'b0;
`ifdef AES_SBOX_SCHED_RR_EN
      last_kw_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      work_q         <= work_d;
      st_out_valid_q <= st_out_valid_d;
      kw_out_valid_q <= kw_out_valid_d;
      busy_q         <= busy_d;
`ifdef AES_SBOX_SCHED_RR_EN
      last_kw_q      <= last_kw_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Self-checking bench for aes_sbox_sched. Expected results come from an
// independent AES S-box table; they are queued on accept and compared when
// the matching output handshake occurs. Honours AES_SBOX_SCHED_RR_EN.
module tb_aes_sbox_sched;

  localparam bit TB_KEY_PRIORITY = 1'b1;

  logic         clk = 1'b0;
  logic         rst;
  logic         st_in_valid, st_in_ready, st_out_valid, st_out_ready;
  logic [127:0] st_in_data, st_out_data;
  logic         kw_in_valid, kw_in_ready, kw_out_valid, kw_out_ready;
  logic [31:0]  kw_in_data, kw_out_data;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] exp_st_q[$];
  logic [31:0]  exp_kw_q[$];
  logic         model_last_kw = 1'b0;

  logic [7:0] sbox_tab [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  aes_sbox_sched #(
    .KEY_PRIORITY (TB_KEY_PRIORITY),
    .ST_BYTES     (16),
    .KW_BYTES     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .st_in_valid  (st_in_valid),
    .st_in_ready  (st_in_ready),
    .st_in_data   (st_in_data),
    .st_out_valid (st_out_valid),
    .st_out_ready (st_out_ready),
    .st_out_data  (st_out_data),
    .kw_in_valid  (kw_in_valid),
    .kw_in_ready  (kw_in_ready),
    .kw_in_data   (kw_in_data),
    .kw_out_valid (kw_out_valid),
    .kw_out_ready (kw_out_ready),
    .kw_out_data  (kw_out_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] sub128(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_tab[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] sub32(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_tab[d[8*i +: 8]];
    return r;
  endfunction

  // Scoreboard: push on accept, pop and compare on output handshake
  always @(negedge clk) begin
    if (rst) begin
      exp_st_q.delete();
      exp_kw_q.delete();
      model_last_kw = 1'b0;
    end else begin
      if (st_in_valid && st_in_ready) begin
        exp_st_q.push_back(sub128(st_in_data));
        model_last_kw = 1'b0;
      end
      if (kw_in_valid && kw_in_ready) begin
        exp_kw_q.push_back(sub32(kw_in_data));
        model_last_kw = 1'b1;
      end
      if (st_out_valid && st_out_ready) begin
        n_cmp++;
        if (exp_st_q.size() == 0) begin
          n_err++;
          $display("[TB] FAIL sb_st_unexpected: got %h, no result expected", st_out_data);
        end else begin
          logic [127:0] e;
          e = exp_st_q.pop_front();
          if (st_out_data !== e) begin
            n_err++;
            $display("[TB] FAIL sb_st_data: got %h expected %h", st_out_data, e);
          end
        end
      end
      if (kw_out_valid && kw_out_ready) begin
        n_cmp++;
        if (exp_kw_q.size() == 0) begin
          n_err++;
          $display("[TB] FAIL sb_kw_unexpected: got %h, no result expected", kw_out_data);
        end else begin
          logic [31:0] e;
          e = exp_kw_q.pop_front();
          if (kw_out_data !== e) begin
            n_err++;
            $display("[TB] FAIL sb_kw_data: got %h expected %h", kw_out_data, e);
          end
        end
      end
    end
  end

  task automatic send_st(input logic [127:0] d);
    int t;
    st_in_data  = d;
    st_in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!st_in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!st_in_ready) begin
      n_cmp++; n_err++;
      $display("[TB] FAIL st_accept_timeout: st_in_ready=%0b required 1", st_in_ready);
    end
    @(posedge clk); #1;
    st_in_valid = 1'b0;
  endtask

  task automatic send_kw(input logic [31:0] d);
    int t;
    kw_in_data  = d;
    kw_in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!kw_in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!kw_in_ready) begin
      n_cmp++; n_err++;
      $display("[TB] FAIL kw_accept_timeout: kw_in_ready=%0b required 1", kw_in_ready);
    end
    @(posedge clk); #1;
    kw_in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_cmp++; n_err++;
      $display("[TB] FAIL %s_idle_timeout: busy=%0b required 0", tag, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    st_in_valid = 1'b0; kw_in_valid = 1'b0;
    st_in_data = '0; kw_in_data = '0;
    st_out_ready = 1'b1; kw_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    n_cmp++; if (st_out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_st_valid: got %0b expected 0", st_out_valid); end
    n_cmp++; if (kw_out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_kw_valid: got %0b expected 0", kw_out_valid); end
    n_cmp++; if (st_out_data !== 128'h0) begin n_err++; $display("[TB] FAIL reset_st_data: got %h expected 0", st_out_data); end
    n_cmp++; if (kw_out_data !== 32'h0) begin n_err++; $display("[TB] FAIL reset_kw_data: got %h expected 0", kw_out_data); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_state_zero();
    int cycles;
    send_st(128'h0);
    cycles = 0;
    while (!st_out_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    n_cmp++; if (cycles != 16) begin n_err++; $display("[TB] FAIL st_latency: got %0d cycles expected 16", cycles); end
    n_cmp++; if (st_out_data !== {16{8'h63}}) begin n_err++; $display("[TB] FAIL st_zero_data: got %h expected %h", st_out_data, {16{8'h63}}); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL st_done_busy: got %0b expected 1", busy); end
    @(posedge clk); #1;
    n_cmp++; if (st_out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("[TB] FAIL st_release: valid=%0b busy=%0b expected 0/0", st_out_valid, busy);
    end
  endtask

  task automatic test_state_vector();
    int t;
    send_st(128'h0f0e0d0c0b0a09080706050403020100);
    t = 0;
    while (!st_out_valid && t < 40) begin @(posedge clk); #1; t++; end
    n_cmp++; if (st_out_data !== 128'h76abd7fe2b670130c56f6bf27b777c63) begin
      n_err++; $display("[TB] FAIL st_vector: got %h expected 76abd7fe2b670130c56f6bf27b777c63", st_out_data);
    end
    wait_idle("st_vector");
  endtask

  task automatic test_key_word();
    int cycles;
    logic bad;
    send_kw(32'hcf4f3c09);
    st_in_data  = 128'h00112233445566778899aabbccddeeff;
    st_in_valid = 1'b1;
    bad = 1'b0;
    cycles = 0;
    while (!kw_out_valid && cycles < 20) begin
      if (st_in_ready) bad = 1'b1;
      @(posedge clk); #1;
      cycles++;
      if (st_in_ready) bad = 1'b1;
    end
    st_in_valid = 1'b0;
    n_cmp++; if (cycles != 4) begin n_err++; $display("[TB] FAIL kw_latency: got %0d cycles expected 4", cycles); end
    n_cmp++; if (kw_out_data !== 32'h8a84eb01) begin n_err++; $display("[TB] FAIL kw_vector: got %h expected 8a84eb01", kw_out_data); end
    n_cmp++; if (bad !== 1'b0) begin n_err++; $display("[TB] FAIL kw_st_blocked: st_in_ready seen=%0b expected 0", bad); end
    wait_idle("kw_vector");
  endtask

  task automatic test_simultaneous(input string tag);
    logic exp_kw_first;
    logic loser_rdy;
    int t;
`ifdef AES_SBOX_SCHED_RR_EN
    exp_kw_first = ~model_last_kw;
`else
    exp_kw_first = TB_KEY_PRIORITY;
`endif
    st_in_data  = {$urandom, $urandom, $urandom, $urandom};
    kw_in_data  = $urandom;
    st_in_valid = 1'b1;
    kw_in_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if ({kw_in_ready, st_in_ready} !== {exp_kw_first, ~exp_kw_first}) begin
      n_err++; $display("[TB] FAIL %s_grant: kw/st ready=%0b%0b expected %0b%0b", tag, kw_in_ready, st_in_ready, exp_kw_first, ~exp_kw_first);
    end
    @(posedge clk); #1;
    if (exp_kw_first) kw_in_valid = 1'b0; else st_in_valid = 1'b0;
    t = 0;
    @(negedge clk);
    loser_rdy = exp_kw_first ? st_in_ready : kw_in_ready;
    while (!loser_rdy && t < 100) begin
      @(negedge clk);
      t++;
      loser_rdy = exp_kw_first ? st_in_ready : kw_in_ready;
    end
    n_cmp++; if (!loser_rdy || (exp_kw_first ? exp_kw_q.size() : exp_st_q.size()) != 0) begin
      n_err++; $display("[TB] FAIL %s_loser: ready=%0b winner_pending=%0d expected 1/0", tag, loser_rdy,
                        exp_kw_first ? exp_kw_q.size() : exp_st_q.size());
    end
    @(posedge clk); #1;
    st_in_valid = 1'b0;
    kw_in_valid = 1'b0;
    wait_idle(tag);
  endtask

  task automatic test_hold();
    logic [127:0] d, e;
    int t;
    d = {$urandom, $urandom, $urandom, $urandom};
    e = sub128(d);
    st_out_ready = 1'b0;
    send_st(d);
    t = 0;
    while (!st_out_valid && t < 40) begin @(posedge clk); #1; t++; end
    kw_in_data  = 32'h01234567;
    kw_in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (st_out_valid !== 1'b1 || st_out_data !== e || busy !== 1'b1 || kw_in_ready !== 1'b0) begin
        n_err++; $display("[TB] FAIL hold_c%0d: valid=%0b data=%h busy=%0b kw_rdy=%0b expected 1/%h/1/0",
                          c, st_out_valid, st_out_data, busy, kw_in_ready, e);
      end
    end
    @(posedge clk); #1;
    kw_in_valid  = 1'b0;
    st_out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (st_out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("[TB] FAIL hold_release: valid=%0b busy=%0b expected 0/0", st_out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_job();
    logic seen;
    send_st({$urandom, $urandom, $urandom, $urandom});
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (st_out_valid !== 1'b0 || busy !== 1'b0 || st_out_data !== 128'h0 || kw_out_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL abort_outputs: valid=%0b busy=%0b data=%h expected all 0", st_out_valid, busy, st_out_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (st_out_valid || busy) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("[TB] FAIL abort_no_valid: activity=%0b expected 0", seen); end
    @(posedge clk); #1;
    send_st({$urandom, $urandom, $urandom, $urandom});
    wait_idle("after_abort");
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 4; j++) begin
      send_st({$urandom, $urandom, $urandom, $urandom});
      send_kw($urandom);
    end
    wait_idle("b2b");
    n_cmp++; if (exp_st_q.size() != 0 || exp_kw_q.size() != 0) begin
      n_err++; $display("[TB] FAIL b2b_drain: pending st=%0d kw=%0d expected 0/0", exp_st_q.size(), exp_kw_q.size());
    end
  endtask

  initial begin
    $display("[TB] aes_sbox_sched bench start");
    test_reset();
    test_state_zero();
    test_state_vector();
    test_key_word();
    test_simultaneous("pair_a");
    send_kw(32'h0badf00d);
    wait_idle("single_kw");
    test_simultaneous("pair_b");
    test_hold();
    test_reset_mid_job();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
